// File: rtl/mem_store_buffer.sv
// Store path from EX to the data-memory write port: sb/sh/sw/swl/swr lane alignment,
// an in-order store FIFO, bounded outstanding writes and a pending-store address hit.
module mem_store_buffer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [31:0]         in_data,
    input  logic [4:0]          in_dtl,
    output logic                in_ades,
    output logic                data_req,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [ADDR_W-1:0]   lq_addr,
    output logic                lq_hit,
    output logic                busy
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int OCNT_W = $clog2(MAX_OUTST + 1);
    localparam int TPTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(STRB_W - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } entry_t;

    // ------------------------------------------------------------------ alignment
    logic [1:0]        ea;
    logic              dtl_onehot;
    logic              misaligned;
    logic [3:0]        word_strb;
    logic [31:0]       word_data;
    logic [STRB_W-1:0] in_strb;
    logic [DATA_W-1:0] in_wdata;
    logic [ADDR_W-1:0] in_line;

    assign ea         = in_addr[1:0];
    assign dtl_onehot = (in_dtl != 5'd0) && ((in_dtl & (in_dtl - 5'd1)) == 5'd0);
    assign misaligned = (in_dtl[2] && in_addr[0]) || (in_dtl[0] && (ea != 2'd0));
    assign in_ades    = in_valid && dtl_onehot && misaligned;
    assign in_line    = in_addr & LINE_MASK;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        word_strb = 4'b0000;
        word_data = 32'h0;
        if (in_dtl[0]) begin
            word_strb = 4'b1111;
            word_data = in_data;
        end else if (in_dtl[1]) begin
            word_strb = 4'b0001 << ea;
            word_data = {24'h0, in_data[7:0]} << {ea, 3'b000};
        end else if (in_dtl[2]) begin
            word_strb = ea[1] ? 4'b1100 : 4'b0011;
            word_data = ea[1] ? {in_data[15:0], 16'h0} : {16'h0, in_data[15:0]};
        end else if (in_dtl[3]) begin
            word_strb = 4'b1111 >> ~ea;
            word_data = in_data >> {~ea, 3'b000};
        end else if (in_dtl[4]) begin
            word_strb = 4'b1111 << ea;
            word_data = in_data << {ea, 3'b000};
        end
    end

    generate
        if (DATA_W == 64) begin : g_lane64
            assign in_strb  = in_addr[2] ? {word_strb, 4'b0000} : {4'b0000, word_strb};
            assign in_wdata = in_addr[2] ? {word_data, 32'h0} : {32'h0, word_data};
        end else begin : g_lane32
            assign in_strb  = word_strb;
            assign in_wdata = word_data;
        end
    endgenerate

    // ------------------------------------------------------------------ store FIFO
    entry_t            fifo_mem [DEPTH];
    logic [DEPTH-1:0]  fifo_valid;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [OCNT_W-1:0] outst;
    logic              full;
    logic              empty;
    logic              enq;
    logic              deq;
    logic              done;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign in_ready   = !full;
    assign enq        = in_valid && in_ready && dtl_onehot && !misaligned;
    assign data_req   = !empty && (outst < OCNT_W'(MAX_OUTST));
    assign deq        = data_req && data_addr_ok;
    assign done       = data_data_ok && (outst != '0);
    assign busy       = !empty || (outst != '0);
    assign data_addr  = fifo_mem[rd_ptr].addr;
    assign data_wstrb = fifo_mem[rd_ptr].strb;
    assign data_wdata = fifo_mem[rd_ptr].data;

    // Addresses of writes that have handshaken but not yet seen data_ok, oldest first.
    logic [ADDR_W-1:0]    tag_addr [MAX_OUTST];
    logic [MAX_OUTST-1:0] tag_valid;
    logic [TPTR_W-1:0]    tag_wr;
    logic [TPTR_W-1:0]    tag_rd;

    function automatic logic [TPTR_W-1:0] tag_next(input logic [TPTR_W-1:0] p);
        return (p == TPTR_W'(MAX_OUTST - 1)) ? '0 : p + TPTR_W'(1);
    endfunction

    // NOTE: payload arrays carry no reset; fifo_valid, tag_valid and count qualify every use.
    always_ff @(posedge clk) begin
        if (enq) fifo_mem[wr_ptr] <= '{addr: in_line, strb: in_strb, data: in_wdata};
        if (deq) tag_addr[tag_wr] <= fifo_mem[rd_ptr].addr;
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            outst      <= '0;
            fifo_valid <= '0;
            tag_wr     <= '0;
            tag_rd     <= '0;
            tag_valid  <= '0;
        end else begin
            if (enq) begin
                fifo_valid[wr_ptr] <= 1'b1;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                fifo_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= rd_ptr + PTR_W'(1);
                tag_valid[tag_wr]  <= 1'b1;
                tag_wr             <= tag_next(tag_wr);
            end
            if (done) begin
                tag_valid[tag_rd] <= 1'b0;
                tag_rd            <= tag_next(tag_rd);
            end
            count <= count + CNT_W'(enq) - CNT_W'(deq);
            outst <= outst + OCNT_W'(deq) - OCNT_W'(done);
        end
    end

    // ------------------------------------------------------------------ load ordering
    logic [ADDR_W-1:0] lq_line;
    assign lq_line = lq_addr & LINE_MASK;

    always_comb begin
        lq_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_mem[i].addr == lq_line)) lq_hit = 1'b1;
        end
        for (int j = 0; j < MAX_OUTST; j++) begin
            if (tag_valid[j] && (tag_addr[j] == lq_line)) lq_hit = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: a 32-bit and a 64-bit instance checked every cycle against
// a byte-level queue model, plus hand-computed directed expectations.
module tb_mem_store_buffer;
    localparam int DEPTH     = 4;
    localparam int MAX_OUTST = 2;

    localparam logic [4:0] T_SW  = 5'b00001;
    localparam logic [4:0] T_SB  = 5'b00010;
    localparam logic [4:0] T_SH  = 5'b00100;
    localparam logic [4:0] T_SWL = 5'b01000;
    localparam logic [4:0] T_SWR = 5'b10000;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  strb;
        logic [63:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // index 0 drives the DATA_W=32 instance, index 1 the DATA_W=64 instance
    logic [1:0]       in_valid, in_ready, in_ades, data_req, addr_ok, data_ok, lq_hit, busy;
    logic [1:0][31:0] in_addr, in_data, lq_addr, data_addr;
    logic [1:0][4:0]  in_dtl;
    logic [3:0]       strb0;
    logic [7:0]       strb1;
    logic [31:0]      wd0;
    logic [63:0]      wd1;
    logic [1:0][7:0]  o_strb;
    logic [1:0][63:0] o_wdata;

    assign o_strb[0]  = {4'h0, strb0};
    assign o_strb[1]  = strb1;
    assign o_wdata[0] = {32'h0, wd0};
    assign o_wdata[1] = wd1;

    mem_store_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) u_dut32 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_addr(in_addr[0]),
        .in_data(in_data[0]), .in_dtl(in_dtl[0]), .in_ades(in_ades[0]),
        .data_req(data_req[0]), .data_addr(data_addr[0]), .data_wstrb(strb0), .data_wdata(wd0),
        .data_addr_ok(addr_ok[0]), .data_data_ok(data_ok[0]),
        .lq_addr(lq_addr[0]), .lq_hit(lq_hit[0]), .busy(busy[0])
    );

    mem_store_buffer #(.ADDR_W(32), .DATA_W(64), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) u_dut64 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_addr(in_addr[1]),
        .in_data(in_data[1]), .in_dtl(in_dtl[1]), .in_ades(in_ades[1]),
        .data_req(data_req[1]), .data_addr(data_addr[1]), .data_wstrb(strb1), .data_wdata(wd1),
        .data_addr_ok(addr_ok[1]), .data_data_ok(data_ok[1]),
        .lq_addr(lq_addr[1]), .lq_hit(lq_hit[1]), .busy(busy[1])
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // ---------------------------------------------------------------- model
    function automatic logic [31:0] line_of(input int c, input logic [31:0] a);
        return (c == 1) ? {a[31:3], 3'b000} : {a[31:2], 2'b00};
    endfunction

    // Memory-byte view: bytes lo..hi of the word are written, byte k taking rt byte (k - src).
    function automatic void model_align(input int c, input logic [31:0] a, input logic [31:0] d,
                                        input logic [4:0] t, output bit legal, output bit ades,
                                        output ent_t e);
        int ea, lo, hi, src, lane, pos;
        logic [7:0]  s;
        logic [63:0] w;
        ea    = int'(a[1:0]);
        lane  = (c == 1) ? int'(a[2]) : 0;
        legal = ($countones(t) == 1);
        ades  = legal && ((t[2] && a[0]) || (t[0] && ea != 0));
        lo = 0; hi = -1; src = 0;
        if (t[0])      begin lo = 0;  hi = 3;      src = 0;      end
        else if (t[1]) begin lo = ea; hi = ea;     src = ea;     end
        else if (t[2]) begin lo = ea; hi = ea + 1; src = ea;     end
        else if (t[3]) begin lo = 0;  hi = ea;     src = ea - 3; end
        else if (t[4]) begin lo = ea; hi = 3;      src = ea;     end
        if (ades) hi = -1;
        s = '0;
        w = '0;
        for (int k = lo; k <= hi; k++) begin
            pos = k + 4 * lane;
            s[pos] = 1'b1;
            w[8*pos +: 8] = d[8*(k-src) +: 8];
        end
        e.addr = line_of(c, a);
        e.strb = s;
        e.data = w;
    endfunction

    ent_t        mq[2][$];
    logic [31:0] mtag[2][$];

    always @(posedge clk or negedge resetn) begin : model
        ent_t e;
        bit   legal, ades, req, rdy;
        if (!resetn) begin
            for (int c = 0; c < 2; c++) begin
                mq[c].delete();
                mtag[c].delete();
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                req = (mq[c].size() != 0) && (mtag[c].size() < MAX_OUTST);
                rdy = (mq[c].size() < DEPTH);
                if (data_ok[c] && mtag[c].size() != 0) void'(mtag[c].pop_front());
                if (req && addr_ok[c]) begin
                    mtag[c].push_back(mq[c][0].addr);
                    void'(mq[c].pop_front());
                end
                if (in_valid[c] && rdy) begin
                    model_align(c, in_addr[c], in_data[c], in_dtl[c], legal, ades, e);
                    if (legal && !ades) mq[c].push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        ent_t        e;
        bit          legal, ades, exp_req, hit;
        logic [31:0] line;
        for (int c = 0; c < 2; c++) begin
            model_align(c, in_addr[c], in_data[c], in_dtl[c], legal, ades, e);
            check($sformatf("c%0d in_ades", c), 64'(in_ades[c]), 64'(in_valid[c] && ades));
            check($sformatf("c%0d in_ready", c), 64'(in_ready[c]), 64'(mq[c].size() < DEPTH));
            check($sformatf("c%0d busy", c), 64'(busy[c]),
                  64'(mq[c].size() != 0 || mtag[c].size() != 0));
            exp_req = (mq[c].size() != 0) && (mtag[c].size() < MAX_OUTST);
            check($sformatf("c%0d data_req", c), 64'(data_req[c]), 64'(exp_req));
            if (exp_req) begin
                check($sformatf("c%0d data_addr", c), 64'(data_addr[c]), 64'(mq[c][0].addr));
                check($sformatf("c%0d data_wstrb", c), 64'(o_strb[c]), 64'(mq[c][0].strb));
                check($sformatf("c%0d data_wdata", c), o_wdata[c], mq[c][0].data);
            end
            line = line_of(c, lq_addr[c]);
            hit  = 1'b0;
            for (int i = 0; i < mq[c].size(); i++) if (mq[c][i].addr == line) hit = 1'b1;
            for (int i = 0; i < mtag[c].size(); i++) if (mtag[c][i] == line) hit = 1'b1;
            check($sformatf("c%0d lq_hit", c), 64'(lq_hit[c]), 64'(hit));
        end
    end

    // ---------------------------------------------------------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] t);
        int n = 0;
        in_valid[c] = 1'b1;
        in_addr[c]  = a;
        in_data[c]  = d;
        in_dtl[c]   = t;
        while (!in_ready[c] && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready[c]) check($sformatf("c%0d send ready timeout", c), 64'(in_ready[c]), 64'd1);
        tick();
        in_valid[c] = 1'b0;
    endtask

    task automatic drain(input int c);
        int n = 0;
        addr_ok[c] = 1'b1;
        data_ok[c] = 1'b1;
        while (busy[c] && n < 50) begin
            tick();
            n++;
        end
        check($sformatf("c%0d drain busy", c), 64'(busy[c]), 64'd0);
        addr_ok[c] = 1'b0;
        data_ok[c] = 1'b0;
    endtask

    logic [4:0] sweep_t [4];

    initial begin
        in_valid = '0; in_addr = '0; in_data = '0; in_dtl = '0;
        addr_ok  = '0; data_ok = '0; lq_addr = '0;
        sweep_t  = '{T_SB, T_SH, T_SWL, T_SWR};
        resetn = 1'b1;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'h3);
        check("reset data_req", 64'(data_req), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset lq_hit", 64'(lq_hit), 64'h0);
        #1 resetn = 1'b1;
        tick();

        // sb at byte 3 of a 32-bit word
        send(0, 32'h1003, 32'h0000_00AB, T_SB);
        lq_addr[0] = 32'h1001;
        @(negedge clk);
        check("sb data_req", 64'(data_req[0]), 64'd1);
        check("sb data_addr", 64'(data_addr[0]), 64'h1000);
        check("sb wstrb", 64'(strb0), 64'b1000);
        check("sb wdata", 64'(wd0), 64'hAB00_0000);
        check("sb lq_hit", 64'(lq_hit[0]), 64'd1);
        tick();
        drain(0);

        // swl then swr, issued in order
        send(0, 32'h2001, 32'h1122_3344, T_SWL);
        send(0, 32'h2002, 32'h1122_3344, T_SWR);
        @(negedge clk);
        check("swl wstrb", 64'(strb0), 64'b0011);
        check("swl wdata", 64'(wd0), 64'h0000_1122);
        tick();
        addr_ok[0] = 1'b1;
        tick();
        addr_ok[0] = 1'b0;
        @(negedge clk);
        check("swr wstrb", 64'(strb0), 64'b1100);
        check("swr wdata", 64'(wd0), 64'h3344_0000);
        tick();
        drain(0);

        // fill to DEPTH with addr_ok low; the fifth store is held until one dequeue
        for (int i = 0; i < 4; i++) send(0, 32'h5000 + 32'(4 * i), 32'hA000_0000 + 32'(i), T_SW);
        @(negedge clk);
        check("full in_ready", 64'(in_ready[0]), 64'd0);
        tick();
        in_valid[0] = 1'b1; in_addr[0] = 32'h5010; in_data[0] = 32'hA000_0004; in_dtl[0] = T_SW;
        tick();
        tick();
        addr_ok[0] = 1'b1;
        tick();
        addr_ok[0] = 1'b0;
        @(negedge clk);
        check("after pop in_ready", 64'(in_ready[0]), 64'd1);
        tick();
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("refull in_ready", 64'(in_ready[0]), 64'd0);
        tick();
        drain(0);

        // outstanding limit
        for (int i = 0; i < 3; i++) send(0, 32'h8000 + 32'(4 * i), 32'h0BAD_0000 + 32'(i), T_SW);
        addr_ok[0] = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("outst cap data_req", 64'(data_req[0]), 64'd0);
        check("outst cap busy", 64'(busy[0]), 64'd1);
        tick();
        data_ok[0] = 1'b1;
        tick();
        data_ok[0] = 1'b0;
        @(negedge clk);
        check("third issue data_req", 64'(data_req[0]), 64'd1);
        tick();
        data_ok[0] = 1'b1;
        tick();
        tick();
        data_ok[0] = 1'b0;
        addr_ok[0] = 1'b0;
        @(negedge clk);
        check("outst drained busy", 64'(busy[0]), 64'd0);
        tick();

        // misaligned and illegal store types are consumed without enqueue
        in_valid[0] = 1'b1; in_addr[0] = 32'h3001; in_data[0] = 32'h1234_5678; in_dtl[0] = T_SH;
        @(negedge clk);
        check("sh 3001 in_ades", 64'(in_ades[0]), 64'd1);
        tick();
        in_addr[0] = 32'h3002; in_dtl[0] = T_SW;
        @(negedge clk);
        check("sw 3002 in_ades", 64'(in_ades[0]), 64'd1);
        tick();
        in_addr[0] = 32'h3000; in_dtl[0] = 5'b00011;
        @(negedge clk);
        check("bad dtl in_ades", 64'(in_ades[0]), 64'd0);
        tick();
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("ades no enqueue busy", 64'(busy[0]), 64'd0);
        tick();
        send(0, 32'h3002, 32'hCAFE_1234, T_SH);
        @(negedge clk);
        check("sh 3002 wstrb", 64'(strb0), 64'b1100);
        check("sh 3002 wdata", 64'(wd0), 64'h1234_0000);
        tick();
        drain(0);

        // sweep every byte offset and partial type on both widths with the bus always ready
        addr_ok = 2'b11;
        data_ok = 2'b11;
        for (int c = 0; c < 2; c++)
            for (int t = 0; t < 4; t++)
                for (int ea = 0; ea < 4; ea++)
                    send(c, 32'h6000 + 32'(ea) + ((c == 1 && t[0]) ? 32'd4 : 32'd0),
                         32'h1122_3344 + 32'(ea * 32'h0101_0101), sweep_t[t]);
        drain(0);
        drain(1);

        // 64-bit bus, upper lane
        send(1, 32'h4004, 32'hDEAD_BEEF, T_SW);
        lq_addr[1] = 32'h4007;
        @(negedge clk);
        check("w64 data_addr", 64'(data_addr[1]), 64'h4000);
        check("w64 wstrb", 64'(strb1), 64'hF0);
        check("w64 wdata", wd1, 64'hDEAD_BEEF_0000_0000);
        check("w64 lq_hit queued", 64'(lq_hit[1]), 64'd1);
        tick();
        addr_ok[1] = 1'b1;
        tick();
        addr_ok[1] = 1'b0;
        @(negedge clk);
        check("w64 lq_hit in flight", 64'(lq_hit[1]), 64'd1);
        tick();
        data_ok[1] = 1'b1;
        tick();
        data_ok[1] = 1'b0;
        @(negedge clk);
        check("w64 lq_hit after data_ok", 64'(lq_hit[1]), 64'd0);
        tick();

        // reset while stores are queued and in flight
        send(1, 32'h400D, 32'h0000_0077, T_SB);
        @(negedge clk);
        check("w64 sb wstrb", 64'(strb1), 64'h20);
        check("w64 sb wdata", wd1, 64'h0000_7700_0000_0000);
        tick();
        addr_ok[1] = 1'b1;
        tick();
        addr_ok[1] = 1'b0;
        send(1, 32'h4010, 32'h5555_0001, T_SW);
        send(1, 32'h4014, 32'h5555_0002, T_SW);
        send(0, 32'h7000, 32'h5555_0003, T_SW);
        lq_addr[1] = 32'h400F;
        @(negedge clk);
        check("pre-reset lq_hit", 64'(lq_hit[1]), 64'd1);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("mid reset data_req", 64'(data_req), 64'h0);
        check("mid reset lq_hit", 64'(lq_hit), 64'h0);
        check("mid reset busy", 64'(busy), 64'h0);
        @(negedge clk);
        #1 resetn = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Parametrised store path between EX and the data-memory request interface.
- Accepts one store per cycle from EX and performs sb/sh/sw/swl/swr lane alignment and byte-strobe generation for a 32- or 64-bit data bus.
- Queues aligned stores in a DEPTH-entry FIFO, issues them on a req/addr_ok/data_ok interface with bounded outstanding writes, and reports pending-store address hits for load ordering.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, memory data bus width; legal values 32 or 64.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- MAX_OUTST, 2, maximum issued writes awaiting data_ok; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  EX presents a store.
- in_ready  out  1  buffer can accept a store.
- in_addr  in  ADDR_W  effective byte address.
- in_data  in  32  rt register value.
- in_dtl  in  5  one-hot store type: [0] sw, [1] sb, [2] sh, [3] swl, [4] swr.
- in_ades  out  1  combinational misaligned-store flag for the current in_valid.
- data_req  out  1  write request valid.
- data_addr  out  ADDR_W  bus-aligned address.
- data_wstrb  out  DATA_W/8  byte strobes.
- data_wdata  out  DATA_W  lane-aligned write data.
- data_addr_ok  in  1  request accepted this cycle.
- data_data_ok  in  1  one earlier write completed.
- lq_addr  in  ADDR_W  load address to check.
- lq_hit  out  1  a queued or in-flight store targets the same bus-aligned address.
- busy  out  1  FIFO non-empty or outstanding count non-zero.

Behaviour:
- Reset (async, resetn=0): rd/wr pointers, entry count, outstanding count and all entry valid bits go to 0. data_req=0, lq_hit=0, busy=0, in_ready=1.
- Alignment uses ea=in_addr[1:0] within a 32-bit word:
  - sw: strb 1111, data unchanged.
  - sb: strb 0001<<ea, data = byte0<<(8*ea).
  - sh: ea 00 gives strb 0011, data in [15:0]; ea 10 gives strb 1100, data in [31:16].
  - swl: strb 0001/0011/0111/1111 for ea 0..3; data = in_data>>(8*(3-ea)).
  - swr: strb 1111/1110/1100/1000 for ea 0..3; data = in_data<<(8*ea).
- DATA_W=64: lane = in_addr[2]; a 32-bit result in lane 1 shifts strb left 4 and data left 32.
- data_addr = in_addr with the low log2(DATA_W/8) bits cleared.
- in_ades = in_valid & ((sh & in_addr[0]) | (sw & in_addr[1:0]!=0)). A flagged store is consumed (in_ready unaffected) and not enqueued.
- in_dtl zero or not one-hot: store is consumed, not enqueued, in_ades=0.
- Enqueue on in_valid & in_ready & legal. The entry stores aligned addr, strb and wdata.
- in_ready = !full. There is no same-cycle bypass: when full, in_ready=0 even if a dequeue occurs that cycle.
- Latency: an entry enqueued at edge N can assert data_req from cycle N+1.
- data_req = !empty & (outst < MAX_OUTST). data_addr/wstrb/wdata come from the head entry and are held stable while data_req=1 and data_addr_ok=0.
- Dequeue on data_req & data_addr_ok: head pointer advances and outst increments.
- data_data_ok decrements outst. Handshake and data_ok in the same cycle leave outst unchanged.
- data_data_ok with outst=0 is ignored.
- Pointers wrap modulo DEPTH. Simultaneous enqueue and dequeue keeps the count unchanged. An enqueue while empty never appears on the bus the same cycle.
- lq_hit compares bus-aligned lq_addr against every valid FIFO entry, and against the addresses of in-flight writes (a MAX_OUTST-deep tag queue, popped on data_ok). It is combinational.
- Store ordering is strict FIFO; no merging.
- resetn falling mid-operation discards all entries and outstanding state immediately. Responses arriving after reset are the system's responsibility.

Test Plan:
- DATA_W=32: sb addr 0x1003, data 0x000000AB -> next cycle data_req=1, data_addr 0x1000, wstrb 1000, wdata 0xAB000000.
- swl 0x2001, data 0x11223344 -> wstrb 0011, wdata 0x00001122. Then swr 0x2002, same data -> wstrb 1100, wdata 0x33440000; both issued in order.
- DEPTH=4, data_addr_ok=0, five back-to-back sw -> in_ready=0 after the fourth enqueue and the fifth is held. One addr_ok pulse -> in_ready=1 the next cycle and the fifth enqueues.
- MAX_OUTST=2, data_addr_ok=1, data_data_ok=0 with three stores queued -> two handshakes, then data_req=0 and busy=1. One data_ok pulse -> third issues. Two more data_ok pulses -> busy=0.
- sh addr 0x3001 and sw addr 0x3002 -> in_ades=1 for each and FIFO count stays 0. A following sh 0x3002 -> wstrb 1100.
- DATA_W=64: sw addr 0x4004, data 0xDEADBEEF -> data_addr 0x4000, wstrb 0xF0, wdata 0xDEADBEEF00000000. lq_addr 0x4007 -> lq_hit=1 until data_ok. Assert resetn=0 mid-queue -> data_req=0, lq_hit=0 and busy=0 immediately.
